// File: rtl/rvcpu_pkg.sv
// Shared CPU definitions: ALU function codes, operand-select encodings, default widths.
// Combinational helpers only; no latency or backpressure of its own.
package rvcpu_pkg;

  localparam int XLEN_DEFAULT   = 64;
  localparam int REG_AW_DEFAULT = 5;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_SLL    = 4'b0001;
  localparam logic [3:0] ALU_SLT    = 4'b0010;
  localparam logic [3:0] ALU_SLTU   = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_SRA    = 4'b1101;
  localparam logic [3:0] ALU_OR     = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_PASS_B = 4'b1110;

  localparam logic SRCA_RS1 = 1'b0;
  localparam logic SRCA_PC  = 1'b1;
  localparam logic SRCB_RS2 = 1'b0;
  localparam logic SRCB_IMM = 1'b1;

  // rs1 only matters when operand A is taken from the register file.
  function automatic logic rs1_used(input logic srca_sel);
    return srca_sel == SRCA_RS1;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Register-operand bypass: x0 -> 0, else MEM result, else WB result, else stored value.
// Purely combinational, zero latency; no backpressure.
module operand_fwd_mux
  import rvcpu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] tag,
  input  logic [XLEN-1:0]   stored,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   value
);

  always_comb begin
    value = stored;
    if (tag == '0) begin
      value = '0;
    end else if (mem_reg_write && (mem_rd_addr == tag)) begin
      value = mem_result;
    end else if (wb_reg_write && (wb_rd_addr == tag)) begin
      value = wb_result;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID->EX register with operand forwarding (EX_FORWARDING_EN) or full interlock (default).
// Latency 1 cycle; holds entry while ex_ready low, id_ready drops on hold or register hazard.
module ex_operand_stage
  import rvcpu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [3:0]        id_func,
  input  logic              id_srca_sel,
  input  logic              id_srcb_sel,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [XLEN-1:0]   wb_result,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_srca,
  output logic [XLEN-1:0]   ex_srcb,
  output logic [3:0]        ex_func,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_is_load
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [3:0]        func;
    logic              srca_sel;
    logic              srcb_sel;
    logic              reg_write;
    logic              is_load;
  } entry_t;

  entry_t          q;
  logic            valid_q;
  logic            hazard;
  logic            capture;
  logic            hold;
  logic            rs1_live;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  assign rs1_live = rs1_used(id_srca_sel);
  assign hold     = valid_q && !ex_ready;
  assign id_ready = !hazard && (!valid_q || ex_ready);
  assign capture  = id_valid && id_ready;

`ifdef EX_FORWARDING_EN
  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .tag           (q.rs1_addr),
    .stored        (q.rs1_val),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .value         (rs1_fwd)
  );

  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .tag           (q.rs2_addr),
    .stored        (q.rs2_val),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .value         (rs2_fwd)
  );

  // Only a load in EX cannot be bypassed in time; everything else is forwarded.
  always_comb begin
    hazard = 1'b0;
    if (valid_q && q.is_load && (q.rd_addr != '0)) begin
      hazard = (rs1_live && (id_rs1_addr == q.rd_addr)) || (id_rs2_addr == q.rd_addr);
    end
  end
`else
  function automatic logic tag_busy(input logic [REG_AW-1:0] tag,
                                    input logic              we,
                                    input logic [REG_AW-1:0] rd);
    return we && (tag != '0) && (tag == rd);
  endfunction

  logic rs1_busy;
  logic rs2_busy;
  logic unused_fwd;

  assign rs1_fwd = q.rs1_val;
  assign rs2_fwd = q.rs2_val;

  // No bypass paths: wait until every in-flight producer has written the register file.
  assign rs1_busy = tag_busy(id_rs1_addr, valid_q && q.reg_write, q.rd_addr) ||
                    tag_busy(id_rs1_addr, mem_reg_write, mem_rd_addr) ||
                    tag_busy(id_rs1_addr, wb_reg_write, wb_rd_addr);
  assign rs2_busy = tag_busy(id_rs2_addr, valid_q && q.reg_write, q.rd_addr) ||
                    tag_busy(id_rs2_addr, mem_reg_write, mem_rd_addr) ||
                    tag_busy(id_rs2_addr, wb_reg_write, wb_rd_addr);
  assign hazard   = (rs1_live && rs1_busy) || rs2_busy;

  assign unused_fwd = ^{mem_result, wb_result, q.rs1_addr, q.rs2_addr};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q    <= 1'b1;
      q.pc       <= id_pc;
      q.rs1_val  <= id_rs1_data;
      q.rs2_val  <= id_rs2_data;
      q.imm      <= id_imm;
      q.rs1_addr <= id_rs1_addr;
      q.rs2_addr <= id_rs2_addr;
      q.rd_addr  <= id_rd_addr;
      q.func     <= id_func;
      q.srca_sel <= id_srca_sel;
      q.srcb_sel <= id_srcb_sel;
      q.reg_write <= id_reg_write;
      q.is_load  <= id_is_load;
    end else if (hold) begin
`ifdef EX_FORWARDING_EN
      // Latch bypassed values so a WB result is not lost once it retires.
      q.rs1_val <= rs1_fwd;
      q.rs2_val <= rs2_fwd;
`endif
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_srca       = (q.srca_sel == SRCA_PC) ? q.pc : rs1_fwd;
  assign ex_srcb       = (q.srcb_sel == SRCB_IMM) ? q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ex_func       = q.func;
  assign ex_pc         = q.pc;
  assign ex_rd_addr    = q.rd_addr;
  assign ex_reg_write  = q.reg_write;
  assign ex_is_load    = q.is_load;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage with a cycle model of the ID->EX entry and its operand rules.
module tb_ex_operand_stage;
  import rvcpu_pkg::*;

`ifdef EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_ready;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_func;
  logic        id_srca_sel, id_srcb_sel, id_reg_write, id_is_load;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_reg_write, wb_reg_write;
  logic [63:0] mem_result, wb_result;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_srca, ex_srcb, ex_store_data, ex_pc;
  logic [3:0]  ex_func;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_is_load;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_func(id_func), .id_srca_sel(id_srca_sel), .id_srcb_sel(id_srcb_sel),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_result(mem_result), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_srca(ex_srca), .ex_srcb(ex_srcb), .ex_func(ex_func),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic [63:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  func;
    logic        asel, bsel, rw, ld;
  } ent_t;

  ent_t m;
  logic m_valid;
  bit   live = 1'b0;

  function automatic logic [63:0] fwd_val(input logic [4:0] tag, input logic [63:0] stored);
    if (FWD) begin
      if (tag == 5'd0) return 64'd0;
      if (mem_reg_write && mem_rd_addr == tag) return mem_result;
      if (wb_reg_write && wb_rd_addr == tag) return wb_result;
    end
    return stored;
  endfunction

  function automatic logic busy(input logic [4:0] tag);
    return (tag != 5'd0) && ((m_valid && m.rw && m.rd == tag) ||
                             (mem_reg_write && mem_rd_addr == tag) ||
                             (wb_reg_write && wb_rd_addr == tag));
  endfunction

  function automatic logic model_rdy();
    logic u1, hz;
    u1 = (id_srca_sel == SRCA_RS1);
    if (FWD) hz = m_valid && m.ld && (m.rd != 5'd0) &&
                  ((u1 && id_rs1_addr == m.rd) || id_rs2_addr == m.rd);
    else     hz = (u1 && busy(id_rs1_addr)) || busy(id_rs2_addr);
    return !hz && (!m_valid || ex_ready);
  endfunction

  function automatic logic next_valid();
    if (rst || flush) return 1'b0;
    if (id_valid && model_rdy()) return 1'b1;
    if (m_valid && ex_ready) return 1'b0;
    return m_valid;
  endfunction

  function automatic ent_t next_m();
    ent_t n;
    n = m;
    if (rst) n = '0;
    else if (!flush && id_valid && model_rdy()) begin
      n.pc = id_pc;   n.a = id_rs1_data; n.b = id_rs2_data; n.imm = id_imm;
      n.rs1 = id_rs1_addr; n.rs2 = id_rs2_addr; n.rd = id_rd_addr; n.func = id_func;
      n.asel = id_srca_sel; n.bsel = id_srcb_sel; n.rw = id_reg_write; n.ld = id_is_load;
    end else if (!flush && FWD && m_valid && !ex_ready) begin
      n.a = fwd_val(m.rs1, m.a);
      n.b = fwd_val(m.rs2, m.b);
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m_valid <= next_valid();
    m       <= next_m();
    live    <= 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      check("id_ready", 64'(id_ready), 64'(model_rdy()));
      check("ex_valid", 64'(ex_valid), 64'(m_valid));
      if (m_valid) begin
        check("ex_srca", ex_srca, m.asel ? m.pc : fwd_val(m.rs1, m.a));
        check("ex_srcb", ex_srcb, m.bsel ? m.imm : fwd_val(m.rs2, m.b));
        check("ex_store_data", ex_store_data, fwd_val(m.rs2, m.b));
        check("ex_func", 64'(ex_func), 64'(m.func));
        check("ex_pc", ex_pc, m.pc);
        check("ex_rd_addr", 64'(ex_rd_addr), 64'(m.rd));
        check("ex_reg_write", 64'(ex_reg_write), 64'(m.rw));
        check("ex_is_load", 64'(ex_is_load), 64'(m.ld));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [3:0] func, input logic asel,
                        input logic bsel, input logic rw, input logic ld);
    id_pc = pc; id_rs1_data = a; id_rs2_data = b; id_imm = imm;
    id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd; id_func = func;
    id_srca_sel = asel; id_srcb_sel = bsel; id_reg_write = rw; id_is_load = ld;
  endtask

  task automatic clr_fwd();
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    mem_rd_addr = 5'd0; wb_rd_addr = 5'd0;
    mem_result = 64'd0; wb_result = 64'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  k, stalls;
    bit  got;
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0);
    clr_fwd();
    tick(); tick();
    @(negedge clk);
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_srca", ex_srca, 64'd0);
    check("rst_store", ex_store_data, 64'd0);
    check("rst_func", 64'(ex_func), 64'(ALU_ADD));
    tick(); rst = 1'b0;

    // basic ADD, rs1=5 rs2=7
    set_id(64'h1000, 64'd5, 64'd7, 64'd0, 5'd1, 5'd2, 5'd10, ALU_ADD, 0, 0, 1, 0);
    id_valid = 1'b1;
    @(negedge clk); check("t1_id_ready", 64'(id_ready), 64'd1);
    tick(); id_valid = 1'b0;
    @(negedge clk);
    check("t1_ex_valid", 64'(ex_valid), 64'd1);
    check("t1_srca", ex_srca, 64'd5);
    check("t1_srcb", ex_srcb, 64'd7);
    check("t1_func", 64'(ex_func), 64'd0);

    // MEM and WB both match rs1=3: MEM wins
    tick();
    set_id(64'h1004, 64'h11, 64'h22, 64'd0, 5'd3, 5'd2, 5'd0, ALU_SUB, 0, 0, 0, 0);
    id_valid = 1'b1;
    mem_reg_write = 1'b1; mem_rd_addr = 5'd3; mem_result = 64'hAA;
    wb_reg_write  = 1'b1; wb_rd_addr  = 5'd3; wb_result  = 64'hBB;
    @(negedge clk); check("t2_id_ready", 64'(id_ready), FWD ? 64'd1 : 64'd0);
    tick();
    if (!FWD) begin clr_fwd(); tick(); end
    id_valid = 1'b0;
    @(negedge clk);
    check("t2_srca_mem_prio", ex_srca, FWD ? 64'hAA : 64'h11);
    check("t2_srcb", ex_srcb, 64'h22);
    check("t2_func", 64'(ex_func), 64'b1000);

    // x0 never forwards
    tick();
    set_id(64'h1008, 64'h55, 64'h66, 64'd0, 5'd0, 5'd2, 5'd0, ALU_OR, 0, 0, 0, 0);
    id_valid = 1'b1;
    mem_reg_write = 1'b1; mem_rd_addr = 5'd0; mem_result = 64'hAA;
    wb_reg_write  = 1'b1; wb_rd_addr  = 5'd0; wb_result  = 64'hBB;
    tick(); id_valid = 1'b0;
    @(negedge clk); check("t2_srca_x0", ex_srca, FWD ? 64'd0 : 64'h55);

    // WB-only forward on rs2
    tick();
    set_id(64'h100C, 64'h1, 64'h77, 64'd0, 5'd1, 5'd9, 5'd0, ALU_AND, 0, 0, 0, 0);
    id_valid = 1'b1;
    mem_reg_write = 1'b0;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd9; wb_result = 64'hCC;
    tick();
    if (!FWD) begin clr_fwd(); tick(); end
    id_valid = 1'b0;
    @(negedge clk);
    check("t2_srcb_wb", ex_srcb, FWD ? 64'hCC : 64'h77);
    check("t2_store_wb", ex_store_data, FWD ? 64'hCC : 64'h77);

    // hold 3 cycles, WB writes x4 in the first
    tick(); clr_fwd();
    set_id(64'h2000, 64'd1, 64'h9999, 64'd0, 5'd1, 5'd4, 5'd11, ALU_ADD, 0, 0, 1, 0);
    id_valid = 1'b1;
    tick(); id_valid = 1'b0; ex_ready = 1'b0;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd4; wb_result = 64'h1234;
    @(negedge clk); check("t3_hold_id_ready", 64'(id_ready), 64'd0);
    tick(); wb_reg_write = 1'b0;
    tick();
    tick(); ex_ready = 1'b1;
    @(negedge clk);
    check("t3_release_valid", 64'(ex_valid), 64'd1);
    check("t3_srcb_refresh", ex_srcb, FWD ? 64'h1234 : 64'h9999);

    // load rd=6 in EX, consumer reads rs1=6
    tick();
    set_id(64'h3000, 64'd0, 64'd0, 64'd8, 5'd1, 5'd2, 5'd6, ALU_ADD, 0, 1, 1, 1);
    id_valid = 1'b1;
    tick();
    set_id(64'h3004, 64'd0, 64'd3, 64'd0, 5'd6, 5'd2, 5'd12, ALU_ADD, 0, 0, 1, 0);
    k = 0; stalls = 0; got = 1'b0;
    while (!got && k < 10) begin
      mem_reg_write = (k == 1); mem_rd_addr = 5'd6; mem_result = 64'h600;
      wb_reg_write  = (k == 2); wb_rd_addr  = 5'd6; wb_result  = 64'h600;
      id_rs1_data   = (k >= 3) ? 64'h600 : 64'd0;
      @(negedge clk);
      if (id_ready) got = 1'b1;
      else stalls++;
      tick(); k++;
    end
    id_valid = 1'b0;
    mem_reg_write = (k == 1);
    wb_reg_write  = (k == 2);
    check("t4_captured", 64'(got), 64'd1);
    check("t4_stalls", 64'(stalls), FWD ? 64'd1 : 64'd3);
    @(negedge clk); check("t4_srca", ex_srca, 64'h600);

    // flush against a held entry, then against a capture
    tick(); clr_fwd();
    set_id(64'h4000, 64'd1, 64'd2, 64'd0, 5'd1, 5'd2, 5'd0, ALU_XOR, 0, 0, 0, 0);
    id_valid = 1'b1;
    tick(); ex_ready = 1'b0; flush = 1'b1;
    set_id(64'h4004, 64'd3, 64'd4, 64'd0, 5'd1, 5'd2, 5'd0, ALU_SLL, 0, 0, 0, 0);
    @(negedge clk); check("t5_held", 64'(ex_valid), 64'd1);
    tick();
    @(negedge clk);
    check("t5_flush_held", 64'(ex_valid), 64'd0);
    check("t5_id_ready", 64'(id_ready), 64'd1);
    tick(); flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    @(negedge clk); check("t5_flush_capture", 64'(ex_valid), 64'd0);

    // 8 back-to-back instructions
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 8) begin
        set_id(64'h5000 + 64'(4 * i), 64'(i + 1), 64'(2 * i), 64'd0, 5'(i + 1), 5'd1,
               5'd0, ALU_SRA, 0, 0, 0, 0);
        id_valid = 1'b1;
      end else begin
        id_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 8) check("t6_id_ready", 64'(id_ready), 64'd1);
      if (i >= 1) begin
        check("t6_valid", 64'(ex_valid), 64'd1);
        check("t6_pc_order", ex_pc, 64'h5000 + 64'(4 * (i - 1)));
      end
    end
    tick();
    @(negedge clk); check("t6_drain", 64'(ex_valid), 64'd0);

    // reset while holding
    tick();
    set_id(64'h6000, 64'd9, 64'd9, 64'd0, 5'd1, 5'd2, 5'd3, ALU_SLTU, 0, 0, 1, 0);
    id_valid = 1'b1;
    tick(); id_valid = 1'b0; ex_ready = 1'b0;
    @(negedge clk); check("t7_held", 64'(ex_valid), 64'd1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("t7_rst_valid", 64'(ex_valid), 64'd0);
    check("t7_rst_pc", ex_pc, 64'd0);
    ex_ready = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Decode-to-execute pipeline register and operand-selection stage that directly feeds the 64-bit ALU's `SrcA`, `SrcB` and 4-bit `func` inputs. It latches one decoded instruction per handshake and resolves register-source hazards against the MEM and WB stages. It holds its entry under downstream backpressure, supports flush, and presents ALU-ready operands plus store data and writeback tags to the execute stage.

## Interface
- `XLEN`, 64, datapath width; ALU operand width.
- `REG_AW`, 5, register address width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill the held entry and any entry being captured.
- `id_valid` / `id_ready`  in / out  1  decode handshake.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  XLEN  decoded fields.
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  REG_AW  register tags.
- `id_func`  in  4  ALU function code.
- `id_srca_sel`  in  1  0 = rs1, 1 = pc.
- `id_srcb_sel`  in  1  0 = rs2, 1 = imm.
- `id_reg_write`, `id_is_load`  in  1  writeback and load flags.
- `mem_rd_addr`, `wb_rd_addr`  in  REG_AW; `mem_reg_write`, `wb_reg_write`  in  1; `mem_result`, `wb_result`  in  XLEN  forwarding sources.
- `ex_valid` / `ex_ready`  out / in  1  execute handshake.
- `ex_srca`, `ex_srcb`  out  XLEN  ALU operands.
- `ex_func`  out  4  ALU function code.
- `ex_store_data`, `ex_pc`  out  XLEN.
- `ex_rd_addr`  out  REG_AW; `ex_reg_write`, `ex_is_load`  out  1.

## Operation
- Single-entry register. `id_ready = !hazard && (!ex_valid || ex_ready)`. Capture happens on `id_valid && id_ready`.
- Transfer out happens on `ex_valid && ex_ready`. If there is no new capture in that cycle, `ex_valid` clears.
- Forwarding applies to each rs operand independently:
  - Tag x0 always reads 0.
  - Otherwise, MEM forwarding is used if `mem_reg_write` is set and `mem_rd_addr` matches.
  - Otherwise, WB forwarding is used if `wb_reg_write` is set and `wb_rd_addr` matches.
  - Otherwise, the stored value is used.
- MEM has priority over WB.
- Operand mapping:
  - `ex_srca` = sel ? pc : fwd rs1.
  - `ex_srcb` = sel ? imm : fwd rs2.
  - `ex_store_data` = fwd rs2, always.
- Refresh: while the entry is held (`ex_valid && !ex_ready`), the stored rs1 and rs2 values are overwritten each cycle with their forwarded values. This prevents a WB result from being lost after it retires.
- The register file does not bypass. WB-to-ID collisions are handled here via WB forwarding or interlock.
- `flush` takes priority over capture and hold. On the next edge, `ex_valid` = 0 and nothing is captured. `id_ready` is unaffected.
- Reset sets `ex_valid` to 0. All data outputs reset to 0, with `ex_func` = 4'b0000 (ADD).

## Timing
- ID to EX latency is 1 cycle.
- `ex_*` outputs are the registered values after the combinational forwarding muxes. They have a zero-cycle path from `mem_*` and `wb_*`.
- `id_ready` is combinational from `ex_ready`, the hazard logic and the held-entry tags.
- Simultaneous transfer out and capture in the same cycle gives full throughput, one instruction per cycle.
- Reset asserted mid-hold discards the held entry.

## Configuration
- `EX_FORWARDING_EN` defined:
  - Forwarding muxes are active.
  - `hazard` = held entry is a valid load with a nonzero `ex_rd_addr` equal to an incoming rs tag that is used by the instruction. This is a load-use interlock of 1 bubble.
- `EX_FORWARDING_EN` undefined:
  - No forwarding and no refresh.
  - `hazard` = any nonzero, used incoming rs tag that matches a writing tag in EX (held), MEM or WB.
  - The stage stalls until the producer retires.
- An rs tag counts as "used" if it is rs1 with `srca_sel` = 0, or rs2 with `srcb_sel` = 0 or a store. Conservatively, rs2 is always treated as used.

## Structure
- Shared package `rvcpu_pkg` holds:
  - ALU func localparams ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, PASS_B 1110.
  - SRCA/SRCB select encodings.
  - The `XLEN` and `REG_AW` defaults.
- One sub-module, `operand_fwd_mux`: takes a tag and a stored value, plus MEM/WB tags, write-enables and data. It outputs the forwarded value and is instantiated twice.

## Test plan
- Reset, then `id_valid` with ADD, rs1 = 5 and rs2 = 7, and no hazards → 1 cycle later `ex_valid` = 1, `ex_srca` = 5, `ex_srcb` = 7, `ex_func` = 0000.
- Forwarding enabled: rs1 tag = 3 with `mem_rd_addr` = 3 (`mem_result` = 0xAA) and `wb_rd_addr` = 3 (`wb_result` = 0xBB) → `ex_srca` = 0xAA. Repeating with rs tag 0 under the same matches → `ex_srca` = 0.
- Hold `ex_ready` = 0 for 3 cycles while WB writes x4 = 0x1234 for one cycle, then release (rs2 = x4) → `ex_srcb` = 0x1234 on release.
- Held load with rd = 6, followed by an incoming instruction with rs1 = 6 → `id_ready` = 0 for 1 cycle, then capture. Without the macro: `id_ready` stays low until WB of x6.
- `flush` together with `id_valid` and a held entry → next cycle `ex_valid` = 0.
- Back-to-back stream of 8 instructions with `ex_ready` = 1 → 8 consecutive `ex_valid` cycles, in order.
